dbu_param: RTL and testbench
============================

// Module: dbu_param
// PURPOSE
//  Parametrised second-generation debug unit between board I/O (switches, buttons, LEDs, 8-digit 7-seg) and the lab CPU.
//  Gates the CPU clock-enable: continuous run (succ) or single-step (step).
//  Walks a memory/register-file address with inc/dec and shows either that word or a selected CPU status channel.
//  Adds step/inc/dec sync+edge detect, RF-depth wrap and an optional PC breakpoint.
// PARAMETERS
//  DATA_W    32  width of inspected data words (multiple of 4, <= 4*DIGITS)
//  ADDR_W    8   memory inspect address width (<= 14)
//  RF_DEPTH  32  register-file entries; address wraps here when m_rf=0
//  SEL_CH    8   status channels; sel width SEL_W=$clog2(SEL_CH)
//  DIGITS    8   7-seg digits (power of 2)
//  SCAN_W    17  scan-counter width; digit dwell = 2^(SCAN_W-$clog2(DIGITS)) cycles
// PORTS
//  clk       in   1               system clock
//  rst       in   1               synchronous, active-high reset
//  succ      in   1               1 = continuous run, 0 = step mode
//  step      in   1               single-step button (raw level)
//  sel       in   SEL_W           0 = show mem/rf word, else status channel sel
//  m_rf      in   1               1 = memory, 0 = register file
//  inc       in   1               address increment button (raw level)
//  dec       in   1               address decrement button (raw level)
//  m_data    in   DATA_W          memory read data at m_rf_addr
//  rf_data   in   DATA_W          register-file read data at m_rf_addr
//  status    in   SEL_CH*DATA_W   packed CPU status channels; channel k = status[k*DATA_W +: DATA_W]
//  run       out  1               CPU clock enable
//  m_rf_addr out  ADDR_W          inspect address
//  led       out  16              {state[1:0], 14'b0} with m_rf_addr in led[ADDR_W-1:0]
//  SSEG_CA   out  8               segments, active low, {dp,g,f,e,d,c,b,a}
//  SSEG_AN   out  DIGITS          digit enables, active low one-hot
// BEHAVIOUR
//  Reset: state IDLE, run=0, m_rf_addr=0, scan cnt=0, SSEG_AN=~1, SSEG_CA=8'hFF, sync/edge regs 0.
//  step/inc/dec: 2-flop sync + rising-edge detect -> 1-cycle pulse; action 2 edges after first high sample; held level = 1 pulse.
//  FSM: IDLE(run=0) -> RUN when succ=1; RUN(run=1) -> IDLE when succ=0.
//       IDLE + step pulse -> STEP (run=1 exactly 1 cycle) -> RUN if succ else IDLE.
//       Step pulse ignored in RUN. state enc IDLE=0, RUN=1, STEP=2, HALT=3.
//  Address: inc pulse +1, dec pulse -1; both same cycle -> no change.
//       m_rf=1 wraps mod 2^ADDR_W; m_rf=0 wraps 0..RF_DEPTH-1 (RF_DEPTH-1 +1 -> 0, 0 -1 -> RF_DEPTH-1).
//       Any change of m_rf (registered compare) clears addr to 0 next cycle, overriding inc/dec.
//  Display word: sel=0 -> (m_rf ? m_data : rf_data); sel>=SEL_CH -> 0; else status channel sel.
//  Scan: free-running cnt; digit i = cnt[SCAN_W-1 -: $clog2(DIGITS)].
//       Digit i shows nibble word[4i+:4] hex; digits i >= DATA_W/4 blank (CA=8'hFF); dp always off.
//       SSEG_CA/SSEG_AN registered: 1-cycle latency from cnt/word.
//  Reset mid-operation (any state incl. STEP/HALT): run=0 in the next cycle; all regs at reset values.
// CONFIGURATION
//  DBU_BREAKPOINT_EN defined: extra ports pc in DATA_W, bp_addr in DATA_W, bp_valid in 1, bp_hit out 1.
//       In RUN, bp_valid && pc==bp_addr -> run=0 that same cycle (combinational), next state HALT.
//       HALT: run=0, bp_hit=1. step pulse -> STEP -> RUN/IDLE per succ. succ=0 -> IDLE.
//       bp_hit reset 0.
//  Undefined: no extra ports, HALT unreachable, behaviour as above.
// STRUCTURE
//  Package dbu_pkg: state enum, hex->7seg function, BLANK_SEG=8'hFF constant.
//  Sub-module dbu_sseg_scan (cnt, digit select, decode, output regs); rest inline.
// TESTING
//  1 rst=1 2 cycles, succ=1 -> run=1 continuously from cycle after release; m_rf_addr=0; SSEG_AN=8'hFE at reset.
//  2 succ=0, step high 5 cycles -> exactly one run=1 cycle, 2 edges after first high sample; FSM back in IDLE.
//  3 m_rf=1, addr=0: dec -> 8'hFF, inc -> 8'h00, inc+dec together -> unchanged; m_rf=0, addr=31, inc -> 0; toggle m_rf at addr=5 -> 0.
//  4 SCAN_W=4, sel=0, m_rf=1, m_data=32'h1234ABCD -> digit0 AN=8'hFE CA=8'hA1 ('D'); digit7 AN=8'h7F shows '1'; sel=3 shows status ch3.
//  5 DBU_BREAKPOINT_EN, succ=1, bp_valid=1, bp_addr=32'h10, pc 0x0C..0x10 -> run=0 in cycle pc=0x10, HALT, bp_hit=1; step -> 1 run cycle, then RUN.
//  6 rst asserted during STEP and during HALT -> run=0, state IDLE, addr 0, bp_hit 0 next cycle.

Source files
------------

// File: rtl/dbu_pkg.sv
// dbu_pkg -- shared types and helpers for the debug unit.
//   dbu_state_e : FSM state encoding (IDLE=0, RUN=1, STEP=2, HALT=3)
//   BLANK_SEG   : all segments off (active-low)
//   hex2seg     : 4-bit nibble -> active-low {dp,g,f,e,d,c,b,a}, dp off
package dbu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } dbu_state_e;

    localparam logic [7:0] BLANK_SEG = 8'hFF;

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0:    hex2seg = 8'hC0;
            4'h1:    hex2seg = 8'hF9;
            4'h2:    hex2seg = 8'hA4;
            4'h3:    hex2seg = 8'hB0;
            4'h4:    hex2seg = 8'h99;
            4'h5:    hex2seg = 8'h92;
            4'h6:    hex2seg = 8'h82;
            4'h7:    hex2seg = 8'hF8;
            4'h8:    hex2seg = 8'h80;
            4'h9:    hex2seg = 8'h90;
            4'hA:    hex2seg = 8'h88;
            4'hB:    hex2seg = 8'h83;
            4'hC:    hex2seg = 8'hC6;
            4'hD:    hex2seg = 8'hA1;
            4'hE:    hex2seg = 8'h86;
            default: hex2seg = 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/dbu_sseg_scan.sv
// dbu_sseg_scan -- multiplexed 7-segment scanner.
//   clk, rst    : clock, synchronous active-high reset
//   word_i      : word to display, digit i shows nibble word_i[4i+:4]
//   sseg_ca_o   : registered active-low segments (dp always off)
//   sseg_an_o   : registered active-low one-hot digit enable
// The digit index is the top bits of a free-running counter, so each digit
// dwells 2^(SCAN_W-log2(DIGITS)) cycles. Outputs lag cnt/word by one cycle.
module dbu_sseg_scan
    import dbu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 8,
    parameter int SCAN_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] word_i,
    output logic [7:0]        sseg_ca_o,
    output logic [DIGITS-1:0] sseg_an_o
);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB   = DATA_W / 4;

    logic [SCAN_W-1:0]   cnt_q;
    logic [DIG_W-1:0]    dig;
    logic [4*DIGITS-1:0] wpad;
    logic [7:0]          ca_d;
    logic [DIGITS-1:0]   an_d;

    assign dig = cnt_q[SCAN_W-1 -: DIG_W];

    always_comb begin
        // Zero-extend so digits past the data width index safely; they are blanked anyway.
        wpad = '0;
        wpad[DATA_W-1:0] = word_i;
        an_d = ~(DIGITS'(1) << dig);
        ca_d = (int'(dig) < NIB) ? hex2seg(wpad[4*dig +: 4]) : BLANK_SEG;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sseg_an_o <= ~DIGITS'(1);
            sseg_ca_o <= BLANK_SEG;
        end else begin
            cnt_q     <= cnt_q + 1'b1;
            sseg_an_o <= an_d;
            sseg_ca_o <= ca_d;
        end
    end

endmodule

// File: rtl/dbu_param.sv
// dbu_param -- board-side debug unit for the lab CPU.
//   clk, rst          : clock, synchronous active-high reset
//   succ              : 1 = continuous run, 0 = single-step mode
//   step, inc, dec    : raw button levels (synchronised, rising-edge pulsed)
//   sel               : 0 = mem/rf word, otherwise status channel sel
//   m_rf              : 1 = memory, 0 = register file address space
//   m_data, rf_data   : read data at m_rf_addr
//   status            : packed status channels, ch k = status[k*DATA_W +: DATA_W]
//   run               : CPU clock enable
//   m_rf_addr, led    : inspect address; led = {state, 0..., addr}
//   SSEG_CA, SSEG_AN  : active-low 7-seg segments / digit enables
// Optional feature macro DBU_BREAKPOINT_EN adds pc, bp_addr, bp_valid, bp_hit:
// a PC match while running drops run in the same cycle and parks in HALT.
module dbu_param
    import dbu_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int ADDR_W   = 8,
    parameter  int RF_DEPTH = 32,
    parameter  int SEL_CH   = 8,
    parameter  int DIGITS   = 8,
    parameter  int SCAN_W   = 17,
    localparam int SEL_W    = (SEL_CH > 1) ? $clog2(SEL_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     succ,
    input  logic                     step,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     m_rf,
    input  logic                     inc,
    input  logic                     dec,
    input  logic [DATA_W-1:0]        m_data,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic [SEL_CH*DATA_W-1:0] status,
`ifdef DBU_BREAKPOINT_EN
    input  logic [DATA_W-1:0]        pc,
    input  logic [DATA_W-1:0]        bp_addr,
    input  logic                     bp_valid,
    output logic                     bp_hit,
`endif
    output logic                     run,
    output logic [ADDR_W-1:0]        m_rf_addr,
    output logic [15:0]              led,
    output logic [7:0]               SSEG_CA,
    output logic [DIGITS-1:0]        SSEG_AN
);
    localparam logic [ADDR_W-1:0] RF_LAST = ADDR_W'(RF_DEPTH - 1);

    dbu_state_e        state_q;
    logic              run_q;
    logic [2:0]        s1_q, s2_q, s3_q;   // {step, inc, dec} sync chain
    logic              step_p, inc_p, dec_p;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              m_rf_q;
    logic [DATA_W-1:0] word;
    logic              bp_match;

    // Two-flop synchroniser, third flop only for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {step, inc, dec};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign {step_p, inc_p, dec_p} = s2_q & ~s3_q;

`ifdef DBU_BREAKPOINT_EN
    assign bp_match = (state_q == RUN) && bp_valid && (pc == bp_addr);
    assign bp_hit   = (state_q == HALT);
`else
    assign bp_match = 1'b0;
`endif

    // A breakpoint hit must stop the CPU in the very cycle it is seen.
    assign run = run_q & ~bp_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (step_p) begin
                          state_q <= STEP; run_q <= 1'b1;
                      end else if (succ) begin
                          state_q <= RUN;  run_q <= 1'b1;
                      end
                RUN:  if (bp_match) begin
                          state_q <= HALT; run_q <= 1'b0;
                      end else if (!succ) begin
                          state_q <= IDLE; run_q <= 1'b0;
                      end
                STEP: if (succ) begin
                          state_q <= RUN;  run_q <= 1'b1;
                      end else begin
                          state_q <= IDLE; run_q <= 1'b0;
                      end
                HALT: if (step_p) begin
                          state_q <= STEP; run_q <= 1'b1;
                      end else if (!succ) begin
                          state_q <= IDLE; run_q <= 1'b0;
                      end
                default: begin
                          state_q <= IDLE; run_q <= 1'b0;
                      end
            endcase
        end
    end

    // Address walk; a change of address space restarts at 0 and wins over buttons.
    always_comb begin
        addr_d = addr_q;
        if (m_rf != m_rf_q)
            addr_d = '0;
        else if (inc_p && !dec_p)
            addr_d = (!m_rf && addr_q == RF_LAST) ? '0 : addr_q + 1'b1;
        else if (dec_p && !inc_p)
            addr_d = (!m_rf && addr_q == '0) ? RF_LAST : addr_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            m_rf_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            m_rf_q <= m_rf;
        end
    end

    assign m_rf_addr = addr_q;
    assign led       = {state_q, 14'(addr_q)};

    always_comb begin
        word = '0;
        if (sel == '0)
            word = m_rf ? m_data : rf_data;
        else if (int'(sel) < SEL_CH)
            word = status[int'(sel)*DATA_W +: DATA_W];
    end

    dbu_sseg_scan #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS),
        .SCAN_W (SCAN_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .word_i    (word),
        .sseg_ca_o (SSEG_CA),
        .sseg_an_o (SSEG_AN)
    );

endmodule

// File: tb/tb_dbu_param.sv
// Testbench for dbu_param: reference model pushes expected outputs per clock
// edge into a queue; a negedge monitor pops and compares. Directed scenarios
// are followed by a randomized phase.
module tb_dbu_param;
    localparam int DW = 32, SC = 8, SCAN = 4, DWELL = 2;  // DWELL = 2^(SCAN-3)
    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_HALT = 3;
    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic clk = 1'b0;
    logic rst, succ, step, m_rf, inc, dec;
    logic [2:0] sel;
    logic [DW-1:0] m_data, rf_data;
    logic [SC*DW-1:0] status;
    logic run;
    logic [7:0] m_rf_addr, SSEG_CA, SSEG_AN;
    logic [15:0] led;
`ifdef DBU_BREAKPOINT_EN
    logic [DW-1:0] pc, bp_addr;
    logic bp_valid, bp_hit;
`endif

    always #5 clk = ~clk;

    dbu_param #(.DATA_W(DW), .ADDR_W(8), .RF_DEPTH(32), .SEL_CH(SC), .DIGITS(8), .SCAN_W(SCAN)) dut (
        .clk(clk), .rst(rst), .succ(succ), .step(step), .sel(sel), .m_rf(m_rf),
        .inc(inc), .dec(dec), .m_data(m_data), .rf_data(rf_data), .status(status),
`ifdef DBU_BREAKPOINT_EN
        .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit),
`endif
        .run(run), .m_rf_addr(m_rf_addr), .led(led), .SSEG_CA(SSEG_CA), .SSEG_AN(SSEG_AN)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         st;
        bit         run;
        int         addr;
        logic [7:0] an;
        logic [7:0] ca;
    } exp_t;
    exp_t expq[$];

    int m_st = 0, m_addr = 0, m_cnt = 0;
    bit m_prev_mrf = 0;
    logic [2:0] h1 = 0, h2 = 0, h3 = 0;  // raw {step,inc,dec} samples 1, 2, 3 edges ago

    always @(posedge clk) begin
        exp_t e;
        logic [2:0] pls;
        logic [31:0] word;
        int dig;
        bit bp;
        if (rst) begin
            m_st = S_IDLE; m_addr = 0; m_cnt = 0; m_prev_mrf = 0;
            h1 = 0; h2 = 0; h3 = 0;
            e.st = S_IDLE; e.run = 0; e.addr = 0; e.an = 8'hFE; e.ca = 8'hFF;
        end else begin
            // a button acts at the edge two after its first high sample
            pls = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = {step, inc, dec};
            word = (sel == 0) ? (m_rf ? m_data : rf_data) : status[sel*DW +: DW];
            dig = (m_cnt / DWELL) % 8;
            e.an = ~(8'd1 << dig);
            e.ca = SEG[(word >> (4*dig)) & 32'hF];
            m_cnt = (m_cnt + 1) % (1 << SCAN);
            if (m_rf != m_prev_mrf) m_addr = 0;
            else if (pls[1] != pls[0]) begin
                if (m_rf) m_addr = (m_addr + (pls[1] ? 1 : -1) + 256) % 256;
                else      m_addr = (m_addr + (pls[1] ? 1 : -1) + 32) % 32;
            end
            m_prev_mrf = m_rf;
            bp = 0;
`ifdef DBU_BREAKPOINT_EN
            bp = (m_st == S_RUN) && bp_valid && (pc == bp_addr);
`endif
            case (m_st)
                S_IDLE: m_st = pls[2] ? S_STEP : (succ ? S_RUN : S_IDLE);
                S_RUN:  m_st = bp ? S_HALT : (succ ? S_RUN : S_IDLE);
                S_STEP: m_st = succ ? S_RUN : S_IDLE;
                default: m_st = pls[2] ? S_STEP : (succ ? S_HALT : S_IDLE);
            endcase
            e.st = m_st; e.run = (m_st == S_RUN || m_st == S_STEP); e.addr = m_addr;
            e.an = e.an; e.ca = e.ca;
        end
        expq.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        bit er;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            er = e.run;
`ifdef DBU_BREAKPOINT_EN
            if (e.st == S_RUN && bp_valid && pc == bp_addr) er = 0;
            chk("bp_hit", 32'(bp_hit), 32'(e.st == S_HALT));
`endif
            chk("run", 32'(run), 32'(er));
            chk("addr", 32'(m_rf_addr), 32'(e.addr));
            chk("led", 32'(led), 32'((e.st << 14) | e.addr));
            chk("an", 32'(SSEG_AN), 32'(e.an));
            chk("ca", 32'(SSEG_CA), 32'(e.ca));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic i, input logic d);
        inc = i; dec = d;
        cyc(1);
        inc = 0; dec = 0;
        cyc(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, f0, f7, st_first;
        rst = 1; succ = 1; step = 0; sel = 0; m_rf = 0; inc = 0; dec = 0;
        m_data = 0; rf_data = 0; status = '0;
`ifdef DBU_BREAKPOINT_EN
        pc = 0; bp_addr = 0; bp_valid = 0;
`endif
        // 1: reset state, then continuous run
        cyc(2);
        @(negedge clk);
        chk("rst_an", 32'(SSEG_AN), 32'hFE);
        chk("rst_ca", 32'(SSEG_CA), 32'hFF);
        chk("rst_run", 32'(run), 0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1); @(negedge clk);
            chk("succ_run", 32'(run), 1);
            chk("succ_addr", 32'(m_rf_addr), 0);
        end

        // 2: single step from a held button
        succ = 0; cyc(3);
        step = 1; first = -1; f0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 4) step = 0;
            @(negedge clk);
            if (run) begin f0++; if (first < 0) first = i; end
        end
        chk("step_count", 32'(f0), 1);
        chk("step_when", 32'(first), 2);
        chk("step_idle", 32'(led[15:14]), 0);

        // 3: address walk and wrap
        m_rf = 1; cyc(3);
        press(0, 1); @(negedge clk); chk("mem_dec_wrap", 32'(m_rf_addr), 32'hFF);
        press(1, 0); @(negedge clk); chk("mem_inc_wrap", 32'(m_rf_addr), 32'h00);
        press(1, 0); @(negedge clk); chk("mem_inc", 32'(m_rf_addr), 32'h01);
        press(1, 1); @(negedge clk); chk("inc_dec_same", 32'(m_rf_addr), 32'h01);
        m_rf = 0; cyc(2); @(negedge clk); chk("mrf_clear", 32'(m_rf_addr), 0);
        press(0, 1); @(negedge clk); chk("rf_dec_wrap", 32'(m_rf_addr), 31);
        press(1, 0); @(negedge clk); chk("rf_inc_wrap", 32'(m_rf_addr), 0);
        repeat (5) press(1, 0);
        @(negedge clk); chk("rf_addr5", 32'(m_rf_addr), 5);
        m_rf = 1; cyc(2); @(negedge clk); chk("toggle_clear", 32'(m_rf_addr), 0);

        // 4: display scan
        m_data = 32'h1234ABCD;
        for (int k = 0; k < SC; k++) status[k*DW +: DW] = $urandom;
        status[3*DW +: DW] = 32'h89ABCDEF;
        sel = 0; cyc(2); f0 = 0; f7 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (SSEG_AN == 8'hFE) begin f0++; chk("dig0_D", 32'(SSEG_CA), 32'hA1); end
            if (SSEG_AN == 8'h7F) begin f7++; chk("dig7_1", 32'(SSEG_CA), 32'hF9); end
        end
        chk("dig0_seen", 32'(f0 > 0), 1);
        chk("dig7_seen", 32'(f7 > 0), 1);
        sel = 3; cyc(2); f0 = 0; f7 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (SSEG_AN == 8'hFE) begin f0++; chk("ch3_dig0", 32'(SSEG_CA), 32'h8E); end
            if (SSEG_AN == 8'h7F) begin f7++; chk("ch3_dig7", 32'(SSEG_CA), 32'h80); end
        end
        chk("ch3_seen", 32'(f0 > 0 && f7 > 0), 1);

        // 6a: reset during STEP
        press(1, 0); press(1, 0);
        step = 1; cyc(1); step = 0; cyc(2);
        @(negedge clk);
        chk("in_step_run", 32'(run), 1);
        chk("in_step_state", 32'(led[15:14]), 2);
        rst = 1; cyc(1); @(negedge clk);
        chk("rst_step_run", 32'(run), 0);
        chk("rst_step_led", 32'(led), 0);
        rst = 0; cyc(2);

`ifdef DBU_BREAKPOINT_EN
        // 5: breakpoint
        succ = 1; bp_valid = 1; bp_addr = 32'h10; pc = 32'h0C; cyc(3);
        for (int k = 0; k < 5; k++) begin
            pc = 32'h0C + k;
            @(negedge clk);
            chk("bp_run", 32'(run), (pc == 32'h10) ? 0 : 1);
            cyc(1);
        end
        pc = 32'h20;
        @(negedge clk);
        chk("halt_hit", 32'(bp_hit), 1);
        chk("halt_run", 32'(run), 0);
        chk("halt_state", 32'(led[15:14]), 3);
        step = 1; first = -1; st_first = -1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) step = 0;
            @(negedge clk);
            if (run && first < 0) begin first = i; st_first = int'(led[15:14]); end
        end
        chk("halt_step_when", 32'(first), 2);
        chk("halt_step_state", 32'(st_first), 2);
        chk("after_step_run", 32'(run), 1);
        chk("after_step_state", 32'(led[15:14]), 1);
        // 6b: reset during HALT
        pc = 32'h10; cyc(1); @(negedge clk);
        chk("rehalt", 32'(led[15:14]), 3);
        rst = 1; cyc(1); @(negedge clk);
        chk("rst_halt_run", 32'(run), 0);
        chk("rst_halt_led", 32'(led), 0);
        chk("rst_halt_hit", 32'(bp_hit), 0);
        rst = 0; bp_addr = 2;
`endif

        // randomized phase
        for (int n = 0; n < 1200; n++) begin
            cyc(1);
            if ($urandom_range(15) == 0) succ = ~succ;
            if ($urandom_range(2) == 0) step = ~step;
            if ($urandom_range(2) == 0) inc = ~inc;
            if ($urandom_range(2) == 0) dec = ~dec;
            if ($urandom_range(31) == 0) m_rf = ~m_rf;
            if ($urandom_range(7) == 0) sel = 3'($urandom);
            if ($urandom_range(3) == 0) m_data = $urandom;
            if ($urandom_range(3) == 0) rf_data = $urandom;
            if ($urandom_range(7) == 0) status[$urandom_range(SC-1)*DW +: DW] = $urandom;
            rst = ($urandom_range(99) == 0);
`ifdef DBU_BREAKPOINT_EN
            pc = $urandom_range(3);
            bp_valid = ($urandom_range(3) != 0);
`endif
        end
        rst = 0; inc = 0; dec = 0; step = 0;
        cyc(4);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
